// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed scan driver for a multi-digit 7-segment display.
// It presents one nibble at a time to a downstream BCD/hex decoder. Each digit slot is a BLANK
// gap (all digits off, to prevent ghosting) followed by a SHOW period with that digit enabled.
// New values are written to a pending register and reach the display only at frame boundaries,
// so a frame never mixes old and new data.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   load        1-cycle strobe: capture value_in/dp_in into the pending register
//   value_in    packed nibbles, [3:0] = digit 0 (rightmost)
//   dp_in       decimal point per digit, bit i -> digit i
//   lz_blank    1: suppress leading zero digits (digit 0 is always shown)
//   nibble_out  nibble for the current digit (registered)
//   dp_out      decimal point for the current digit (registered)
//   dig_sel     digit enables, polarity set by DIG_ACTIVE_LOW (registered)
//   frame_start 1-cycle pulse on entry to digit 0's BLANK phase
module seg_scan_driver #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SCAN_DIV       = 12000,
  parameter int unsigned BLANK_CYC      = 16,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_blank,
  output logic [3:0]            nibble_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_start
);

  localparam int unsigned MaxCyc = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam int unsigned IdxW   = $clog2(DIGITS);

  localparam logic [CntW-1:0]   BlankLast = CntW'(BLANK_CYC - 1);
  localparam logic [CntW-1:0]   ShowLast  = CntW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(DIGITS - 1);
  // All digits off; XOR with this also converts an active-high one-hot to the output polarity.
  localparam logic [DIGITS-1:0] SelOff    = {DIGITS{DIG_ACTIVE_LOW}};

  typedef enum logic [0:0] {StBlank, StShow} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
  logic [4*DIGITS-1:0]   pend_q, pend_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [3:0]            nibble_q, nibble_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     sel_q, sel_d;
  logic                  fs_q, fs_d;

  // lz_mask[i] is set when digit i and every digit above it are zero (never for digit 0).
  logic [DIGITS-1:0]     lz_mask;
  logic                  lz_all_zero;
  logic [DIGITS-1:0]     sel_on;

  always_comb begin
    lz_all_zero = 1'b1;
    lz_mask     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_all_zero = lz_all_zero & (disp_q[4*i +: 4] == 4'h0);
      lz_mask[i]  = lz_all_zero & (i != 0);
    end
  end

  assign sel_on = (DIGITS'(1) << idx_q) ^ SelOff;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CntW'(1);
    idx_d      = idx_q;
    disp_d     = disp_q;
    disp_dp_d  = disp_dp_q;
    pend_d     = pend_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    nibble_d   = nibble_q;
    dp_d       = dp_q;
    sel_d      = sel_q;
    fs_d       = 1'b0;

    unique case (state_q)
      StBlank: begin
        if (cnt_q == BlankLast) begin
          state_d = StShow;
          cnt_d   = '0;
          // lz_blank is taken once here and the enable is held for the whole SHOW phase.
          sel_d   = (lz_blank && lz_mask[idx_q]) ? SelOff : sel_on;
        end
      end
      StShow: begin
        if (cnt_q == ShowLast) begin
          state_d = StBlank;
          cnt_d   = '0;
          sel_d   = SelOff;
          if (idx_q == IdxLast) begin
            idx_d = '0;
            fs_d  = 1'b1;
            if (pend_vld_q) begin
              disp_d     = pend_q;
              disp_dp_d  = pend_dp_q;
              pend_vld_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
          // Data for the next digit comes out at the start of its BLANK gap; on a wrap this
          // already reflects the freshly committed value.
          nibble_d = disp_d[{idx_d, 2'b00} +: 4];
          dp_d     = disp_dp_d[idx_d];
        end
      end
      default: begin
        state_d = StBlank;
        cnt_d   = '0;
      end
    endcase

    // A load coinciding with a commit stays pending; the commit above used the old pending data.
    if (load) begin
      pend_d     = value_in;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBlank;
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_q     <= '0;
      disp_dp_q  <= '0;
      pend_q     <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      nibble_q   <= 4'h0;
      dp_q       <= 1'b0;
      sel_q      <= SelOff;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      disp_dp_q  <= disp_dp_d;
      pend_q     <= pend_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      nibble_q   <= nibble_d;
      dp_q       <= dp_d;
      sel_q      <= sel_d;
      fs_q       <= fs_d;
    end
  end

  assign nibble_out  = nibble_q;
  assign dp_out      = dp_q;
  assign dig_sel     = sel_q;
  assign frame_start = fs_q;

endmodule
